// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: sends one byte + register select to a character LCD as two nibbles (upper first)
//
// Ports:
//   clk       system clock, all logic on rising edge
//   reset     asynchronous, active-low reset
//   in_valid  byte request
//   in_data   byte to send
//   in_rs     register select for the byte (0 = command, 1 = data)
//   in_ready  writer idle, can accept a byte
//   done      one-cycle pulse when a byte fully completes
//   lcd_e     LCD enable strobe
//   lcd_rs    LCD register select
//   lcd_rw    LCD read/write, always 0
//   lcd_db    LCD data nibble
//
// Optional feature: define LCD_LONG_CMD_DELAY_EN to stretch the post-byte wait to
// 82000 cycles after the clear (8'h01) and home (8'h02/8'h03) commands.
module lcd_nibble_writer #(
    parameter int SETUP_CYC  = 2,
    parameter int E_CYC      = 12,
    parameter int HOLD_CYC   = 1,
    parameter int NIBBLE_GAP = 50,
    parameter int BYTE_GAP   = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    output logic       in_ready,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db
);
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    localparam int MAXD = max2(max2(SETUP_CYC, E_CYC), max2(max2(HOLD_CYC, NIBBLE_GAP), BYTE_GAP));
`ifdef LCD_LONG_CMD_DELAY_EN
    localparam int LONG_CYC = 82000;
    localparam int CW = $clog2(max2(MAXD, LONG_CYC) + 1);
`else
    localparam int CW = $clog2(MAXD) + 1;
`endif

    typedef enum logic [3:0] {
        IDLE, UP_SETUP, UP_PULSE, UP_HOLD, UP_GAP, LO_SETUP, LO_PULSE, LO_HOLD, LO_WAIT
    } state_t;

    state_t          state, nxt;
    logic [CW-1:0]   cnt, term;
    logic [3:0]      lo_q;
`ifdef LCD_LONG_CMD_DELAY_EN
    logic            long_q;
`endif

    // term is the last counter value of the current state (duration - 1)
    always_comb begin
        term = CW'(BYTE_GAP - 1);
        case (state)
            UP_SETUP, LO_SETUP: term = CW'(SETUP_CYC - 1);
            UP_PULSE, LO_PULSE: term = CW'(E_CYC - 1);
            UP_HOLD, LO_HOLD:   term = CW'(HOLD_CYC - 1);
            UP_GAP:             term = CW'(NIBBLE_GAP - 1);
`ifdef LCD_LONG_CMD_DELAY_EN
            LO_WAIT:            term = long_q ? CW'(LONG_CYC - 1) : CW'(BYTE_GAP - 1);
`endif
            default:            term = CW'(BYTE_GAP - 1);
        endcase
    end

    assign nxt = (state == LO_WAIT) ? IDLE : state_t'(state + 4'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lo_q     <= '0;
`ifdef LCD_LONG_CMD_DELAY_EN
            long_q   <= 1'b0;
`endif
            in_ready <= 1'b1;
            done     <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_rw   <= 1'b0;
            lcd_db   <= 4'h0;
        end else begin
            done   <= 1'b0;
            lcd_rw <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && in_ready) begin
                    state    <= UP_SETUP;
                    cnt      <= '0;
                    lo_q     <= in_data[3:0];
`ifdef LCD_LONG_CMD_DELAY_EN
                    // clear (01) and home (02/03) commands need the long execution wait
                    long_q   <= !in_rs && (in_data[7:2] == 6'd0) && (in_data[1:0] != 2'd0);
`endif
                    lcd_rs   <= in_rs;
                    lcd_db   <= in_data[7:4];
                    in_ready <= 1'b0;
                end
            end else if (cnt == term) begin
                state <= nxt;
                cnt   <= '0;
                // outputs are registered, so they are set on the edge that enters the state
                lcd_e <= (nxt == UP_PULSE) || (nxt == LO_PULSE);
                if (nxt == LO_SETUP)
                    lcd_db <= lo_q;
                if (nxt == IDLE) begin
                    in_ready <= 1'b1;
                    done     <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lcd_nibble_writer.sv
// tb_lcd_nibble_writer: scoreboard bench for lcd_nibble_writer
module tb_lcd_nibble_writer;
    localparam int E_CYC = 12;
    localparam int SETUP_CYC = 2;

    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, done, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_db;

    int cyc = 0, n_vec = 0, n_bad = 0;

    typedef struct {int start; logic [3:0] db; logic rs;} pulse_t;
    pulse_t pq[$];
    int dq[$];

    lcd_nibble_writer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_rs(in_rs),
        .in_ready(in_ready), .done(done), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_db(lcd_db)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle numbering: cycle k+1 is the cycle following accept edge k.
    task automatic expect_byte(input logic [7:0] d, input logic r, input int k, input bit full);
        int dur;
        dur = 2081;
`ifdef LCD_LONG_CMD_DELAY_EN
        if (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) dur = 82081;
`endif
        pq.push_back('{k + 3, d[7:4], r});
        if (full) begin
            pq.push_back('{k + 68, d[3:0], r});
            dq.push_back(k + dur);
        end
    endtask

    // Called at a negedge with the writer idle; returns at the next negedge.
    task automatic send(input logic [7:0] d, input logic r, input bit full, output int k);
        in_valid = 1'b1;
        in_data  = d;
        in_rs    = r;
        k = cyc + 1;
        expect_byte(d, r, k, full);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic       prev_e = 1'b0;
    int         width = 0, stable = 0, now;
    logic [4:0] bus, bus_prev = 5'h0, bus_pulse = 5'h0;
    pulse_t     p;

    always @(negedge clk) begin
        now = cyc + 1;
        bus = {lcd_rs, lcd_db};
        stable = (bus == bus_prev) ? stable + 1 : 0;
        if (lcd_e && !prev_e) begin
            check("setup_stable", 32'(stable >= SETUP_CYC), 1);
            bus_pulse = bus;
            width = 0;
            if (pq.size() == 0) check("unexpected_pulse", now, 0);
            else begin
                p = pq.pop_front();
                check("pulse_start", now, p.start);
                check("pulse_db", lcd_db, p.db);
                check("pulse_rs", lcd_rs, p.rs);
            end
        end
        if (lcd_e) width++;
        if (!lcd_e && prev_e) begin
            check("pulse_width", width, E_CYC);
            check("hold_stable", bus, bus_pulse);
        end
        if (done) begin
            if (dq.size() == 0) check("unexpected_done", now, 0);
            else check("done_cycle", now, dq.pop_front());
        end
        prev_e = lcd_e;
        bus_prev = bus;
    end

    int k, k1, k2;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_done", done, 0);
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_db", lcd_db, 0);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_ready", in_ready, 1);
        check("idle_e", lcd_e, 0);
        check("idle_db", lcd_db, 0);

        send(8'hA5, 1'b1, 1'b1, k);
        check("busy_ready", in_ready, 0);
        repeat (40) @(negedge clk);
        check("gap_rs", lcd_rs, 1);
        repeat (2039) @(negedge clk);
        check("last_wait_ready", in_ready, 0);
        @(negedge clk);
        check("done_ready", in_ready, 1);
        check("idle_keep_db", lcd_db, 4'h5);
        check("rw_tied", lcd_rw, 0);
        repeat (5) @(negedge clk);

        in_valid = 1'b1;
        in_data  = 8'h41;
        in_rs    = 1'b0;
        k1 = cyc + 1;
        k2 = k1 + 2081;
        expect_byte(8'h41, 1'b0, k1, 1'b1);
        @(negedge clk);
        in_data = 8'hFF;
        in_rs   = 1'b1;
        repeat (70) @(negedge clk);
        check("busy_ignore_db", lcd_db, 4'h1);
        check("busy_ignore_rs", lcd_rs, 0);
        in_data = 8'h42;
        in_rs   = 1'b0;
        expect_byte(8'h42, 1'b0, k2, 1'b1);
        repeat (2011) @(negedge clk);
        in_valid = 1'b0;
        check("b2b_accepted", in_ready, 0);
        check("b2b_upper_db", lcd_db, 4'h4);
        repeat (2085) @(negedge clk);

        send(8'h3C, 1'b1, 1'b0, k);
        repeat (30) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_e", lcd_e, 0);
        check("midrst_db", lcd_db, 0);
        check("midrst_rs", lcd_rs, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2100) @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        send(8'h7E, 1'b0, 1'b1, k);
        repeat (2085) @(negedge clk);

        send(8'h01, 1'b0, 1'b1, k);
`ifdef LCD_LONG_CMD_DELAY_EN
        repeat (82085) @(negedge clk);
`else
        repeat (2085) @(negedge clk);
`endif
        check("pending_pulses", pq.size(), 0);
        check("pending_done", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
